// File: rtl/eth_frame_swap_pkg.sv
// rtl/eth_frame_swap_pkg.sv - shared constants, delay-line entry type and input FSM states
package eth_frame_swap_pkg;

  localparam int MAC_LEN      = 6;
  localparam int HDR_LEN      = 12;
  localparam int SWAP_LATENCY = 7;
  localparam int DELAY_DEPTH  = 13;

  typedef struct packed {
    logic [7:0] data;
    logic       last;
    logic       user;
    logic       valid;
  } delay_entry_t;

  typedef enum logic [1:0] {
    SYNC,
    IDLE,
    FRAME
  } in_state_t;

endpackage

// File: rtl/eth_frame_swap_if.sv
// rtl/eth_frame_swap_if.sv - byte stream without backpressure (data, error, last, valid)
interface eth_frame_swap_if;

  logic [7:0] tdata;
  logic       tuser;
  logic       tlast;
  logic       tvalid;

  modport master (output tdata, output tuser, output tlast, output tvalid);
  modport slave  (input tdata, input tuser, input tlast, input tvalid);

endinterface

// File: rtl/eth_byte_delay_line.sv
// rtl/eth_byte_delay_line.sv - DELAY_DEPTH-entry byte shift register exposing every tap
module eth_byte_delay_line
  import eth_frame_swap_pkg::*;
(
  input  logic         clk,
  input  logic         clr,
  input  delay_entry_t din,
  output delay_entry_t taps [DELAY_DEPTH]
);

  // Only the valid bits are cleared; stale data behind valid=0 is never emitted.
  always_ff @(posedge clk) begin
    taps[0] <= din;
    for (int k = 1; k < DELAY_DEPTH; k++) begin
      taps[k] <= taps[k-1];
    end
    if (clr) begin
      for (int k = 0; k < DELAY_DEPTH; k++) begin
        taps[k].valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/eth_frame_swap.sv
// rtl/eth_frame_swap.sv - swaps destination/source MAC fields of a looped RX frame, fixed 7-clk latency
// Optional statistics counters enabled by defining ETH_FRAME_SWAP_STATS_EN.
module eth_frame_swap
  import eth_frame_swap_pkg::*;
#(
  parameter int CNT_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   swap_en,
  eth_frame_swap_if.slave        s_axis,
  eth_frame_swap_if.master       m_axis
`ifdef ETH_FRAME_SWAP_STATS_EN
  ,
  output logic [CNT_WIDTH-1:0]   frame_count,
  output logic [CNT_WIDTH-1:0]   error_count
`endif
);

  localparam int OUT_TAP = SWAP_LATENCY - 1;
  localparam int HDR_TAP = DELAY_DEPTH - 1;

  in_state_t    state, state_n;
  logic         err_q, err_n;
  logic [3:0]   in_cnt, cnt_n;
  logic         accept;
  logic         runt;
  delay_entry_t din;
  delay_entry_t taps [DELAY_DEPTH];
  delay_entry_t age7;

  logic [3:0]   out_idx;
  logic         swap_q;
  logic         swap_now;
  logic [7:0]   sel_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= SYNC;
      err_q  <= 1'b0;
      in_cnt <= 4'd0;
    end else begin
      state  <= state_n;
      err_q  <= err_n;
      in_cnt <= cnt_n;
    end
  end

  // in_cnt is the index of the current input byte, saturating once the header is complete.
  always_comb begin
    state_n = state;
    err_n   = err_q;
    cnt_n   = in_cnt;
    din     = '0;
    accept  = 1'b0;
    runt    = (in_cnt < 4'(HDR_LEN));
    unique case (state)
      SYNC: begin
        if (!s_axis.tvalid) state_n = IDLE;
      end
      IDLE: begin
        if (s_axis.tvalid) begin
          accept  = 1'b1;
          state_n = s_axis.tlast ? IDLE : FRAME;
        end
      end
      FRAME: begin
        if (s_axis.tvalid) begin
          accept = 1'b1;
          if (s_axis.tlast) state_n = IDLE;
        end else begin
          err_n = 1'b1;
        end
      end
      default: state_n = SYNC;
    endcase
    if (accept) begin
      din.valid = 1'b1;
      din.data  = s_axis.tdata;
      din.last  = s_axis.tlast;
      if (s_axis.tlast) begin
        din.user = s_axis.tuser | err_q | runt;
        err_n    = 1'b0;
        cnt_n    = 4'd0;
      end else if (in_cnt != 4'(HDR_LEN)) begin
        cnt_n = in_cnt + 4'd1;
      end
    end
  end

  eth_byte_delay_line u_delay (
    .clk  (clk),
    .clr  (rst),
    .din  (din),
    .taps (taps)
  );

  assign age7 = taps[OUT_TAP];

  // Byte 0 decides the frame's swap directly from swap_en; later bytes use the latched copy.
  always_comb begin
    swap_now = (out_idx == 4'd0) ? swap_en : swap_q;
    sel_data = age7.data;
    if (swap_now) begin
      if (out_idx < 4'(MAC_LEN)) begin
        sel_data = taps[0].data;
      end else if (out_idx < 4'(HDR_LEN)) begin
        sel_data = taps[HDR_TAP].data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      m_axis.tdata  <= 8'h00;
      m_axis.tuser  <= 1'b0;
      m_axis.tlast  <= 1'b0;
      m_axis.tvalid <= 1'b0;
      out_idx       <= 4'd0;
      swap_q        <= 1'b0;
    end else begin
      m_axis.tvalid <= age7.valid;
      m_axis.tlast  <= age7.valid & age7.last;
      m_axis.tuser  <= age7.valid & age7.user;
      m_axis.tdata  <= age7.valid ? sel_data : 8'h00;
      if (age7.valid) begin
        if (out_idx == 4'd0) swap_q <= swap_en;
        if (age7.last) begin
          out_idx <= 4'd0;
        end else if (out_idx != 4'(HDR_LEN)) begin
          out_idx <= out_idx + 4'd1;
        end
      end
    end
  end

`ifdef ETH_FRAME_SWAP_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_count <= '0;
      error_count <= '0;
    end else if (m_axis.tvalid && m_axis.tlast) begin
      frame_count <= frame_count + 1'b1;
      if (m_axis.tuser) error_count <= error_count + 1'b1;
    end
  end
`else
  logic [CNT_WIDTH-1:0] unused_cnt_width;
  assign unused_cnt_width = '0;
`endif

endmodule

// File: tb/tb_eth_frame_swap.sv
// tb/tb_eth_frame_swap.sv - table-driven frame bench with a cycle-stamped output scoreboard
module tb_eth_frame_swap;

  typedef struct {
    int         len;
    logic       swap;
    int         gap_at;
    int         gap_len;
    logic       b2b;
    logic       toggle;
    logic       in_user;
    logic       exp_user;
  } vec_t;

  typedef struct {
    int         due;
    logic       valid;
    logic [7:0] data;
    logic       last;
    logic       user;
    logic       chk_data;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic swap_en;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  int   exp_frames = 0;
  int   exp_errs = 0;
  exp_t q[$];
  vec_t vecs[15];

  eth_frame_swap_if s_axis ();
  eth_frame_swap_if m_axis ();

`ifdef ETH_FRAME_SWAP_STATS_EN
  logic [31:0] frame_count;
  logic [31:0] error_count;
`endif

  eth_frame_swap #(.CNT_WIDTH(32)) dut (
    .clk     (clk),
    .rst     (rst),
    .swap_en (swap_en),
    .s_axis  (s_axis),
    .m_axis  (m_axis)
`ifdef ETH_FRAME_SWAP_STATS_EN
    ,
    .frame_count (frame_count),
    .error_count (error_count)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s at cyc %0d: got %0h expected %0h", name, cyc, got, want);
    end
  endtask

  function automatic logic [7:0] exp_byte(input int base, input int len, input logic sw, input int j);
    int src;
    src = j;
    if (sw && len > 12) begin
      if (j < 6) src = j + 6;
      else if (j < 12) src = j - 6;
    end
    return 8'(base + src);
  endfunction

  // Output for a byte driven now is due 8 counted cycles later (7 clk latency + sampling edge).
  task automatic drive(input logic v, input logic [7:0] d, input logic l, input logic u,
                       input logic ev, input logic [7:0] ed, input logic el, input logic eu,
                       input logic ecd);
    exp_t e;
    s_axis.tvalid = v;
    s_axis.tdata  = d;
    s_axis.tlast  = l;
    s_axis.tuser  = u;
    e.due = cyc + 8;
    e.valid = ev;
    e.data = ed;
    e.last = el;
    e.user = eu;
    e.chk_data = ecd;
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycle();
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic send_case(input vec_t v, input int base);
    logic l;
    for (int j = 0; j < v.len; j++) begin
      if (j == v.gap_at) begin
        repeat (v.gap_len) idle_cycle();
      end
      if (v.toggle && j == 30) swap_en = ~swap_en;
      l = (j == v.len - 1);
      drive(1'b1, 8'(base + j), l, l & v.in_user,
            1'b1, exp_byte(base, v.len, v.swap, j), l, l & v.exp_user, (v.len > 12));
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0 && q[0].due == cyc) begin
      e = q.pop_front();
      check("tvalid", 32'(m_axis.tvalid), 32'(e.valid));
      if (e.valid) begin
        check("tlast", 32'(m_axis.tlast), 32'(e.last));
        if (e.last) begin
          check("tuser", 32'(m_axis.tuser), 32'(e.user));
          exp_frames++;
          if (e.user) exp_errs++;
        end
        if (e.chk_data) check("tdata", 32'(m_axis.tdata), 32'(e.data));
      end
    end else if (m_axis.tvalid === 1'b1) begin
      check("unexpected_tvalid", 32'(m_axis.tvalid), 32'd0);
    end
  end

  initial begin
    vec_t rv;
    int guard;
    vecs[0]  = '{64, 1'b1, -1, 0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{64, 1'b0, -1, 0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{64, 1'b1, -1, 0, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{60, 1'b1, -1, 0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[4]  = '{8,  1'b1, -1, 0, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[5]  = '{64, 1'b1, -1, 0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{64, 1'b1, 20, 3, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[7]  = '{64, 1'b1, -1, 0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[8]  = '{64, 1'b0, -1, 0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[9]  = '{64, 1'b1, -1, 0, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[10] = '{12, 1'b1, -1, 0, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[11] = '{13, 1'b1, -1, 0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[12] = '{1,  1'b1, -1, 0, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[13] = '{20, 1'b1, -1, 0, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[14] = '{16, 1'b1, -1, 0, 1'b0, 1'b0, 1'b0, 1'b0};

    rst = 1'b1;
    swap_en = 1'b0;
    s_axis.tvalid = 1'b1;
    s_axis.tdata  = 8'hA5;
    s_axis.tlast  = 1'b0;
    s_axis.tuser  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_tvalid", 32'(m_axis.tvalid), 32'd0);
    check("reset_tdata", 32'(m_axis.tdata), 32'd0);
    check("reset_tlast", 32'(m_axis.tlast), 32'd0);
    check("reset_tuser", 32'(m_axis.tuser), 32'd0);
    rst = 1'b0;
    // Stream already in progress when reset releases must be dropped.
    repeat (3) drive(1'b1, 8'hA5, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < 15; i++) begin
      if (i == 0 || !vecs[i-1].b2b) begin
        swap_en = vecs[i].swap;
        repeat (10) idle_cycle();
      end
      send_case(vecs[i], (i * 16) & 255);
    end

    swap_en = 1'b1;
    repeat (10) idle_cycle();
    for (int j = 0; j < 30; j++) begin
      drive(1'b1, 8'(8'h80 + j), 1'b0, 1'b0, 1'b1, exp_byte(8'h80, 64, 1'b1, j), 1'b0, 1'b0, 1'b1);
    end
    rst = 1'b1;
    s_axis.tdata = 8'h9E;
    while (q.size() > 0 && q[q.size()-1].due > cyc) q.delete(q.size() - 1);
    exp_frames = 0;
    exp_errs = 0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int j = 31; j < 64; j++) begin
      drive(1'b1, 8'(8'h80 + j), (j == 63), 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    end
    repeat (10) idle_cycle();
    rv = '{64, 1'b1, -1, 0, 1'b0, 1'b0, 1'b0, 1'b0};
    send_case(rv, 8'h40);

    s_axis.tvalid = 1'b0;
    s_axis.tlast  = 1'b0;
    guard = 0;
    while (q.size() > 0 && guard < 200) begin
      @(posedge clk);
      #1;
      guard++;
    end
    check("drain_timeout", 32'(q.size()), 32'd0);
    repeat (3) @(posedge clk);
    #1;
`ifdef ETH_FRAME_SWAP_STATS_EN
    check("frame_count", frame_count, 32'(exp_frames));
    check("error_count", error_count, 32'(exp_errs));
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
